// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a
// shared req/ack memory port, trap detection and a retire counter.
module mips_mc_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_branch,
    input  logic             dec_jump,
    input  logic             dec_jreg,
    input  logic             dec_regwr,
    input  logic             dec_ovfchk,
    input  logic             br_taken,
    input  logic             alu_of,
    input  logic             dm_error,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             mem_ifetch,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             reg_wr,
    output logic             wb_mem,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [7:0] TMO_LAST =
        (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_instret;
    logic             w_tmo;

    // Fires on the cycle the wait count would reach TIMEOUT.
    assign w_tmo = (TIMEOUT != 0) && (r_wait == TMO_LAST) && !mem_ack;

    always_comb begin
        w_next     = r_state;
        w_cause    = r_cause;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_ifetch = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'd0;
        reg_wr     = 1'b0;
        wb_mem     = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'd0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    mem_ifetch = 1'b1;
                    if (mem_ack) begin
                        ir_wr  = 1'b1;
                        w_next = S_DECODE;
                    end else if (w_tmo) begin
                        w_next  = S_TRAP;
                        w_cause = 2'd3;
                    end
                end
                S_DECODE: w_next = S_EXEC;
                S_EXEC: begin
                    if (dec_ovfchk && alu_of) begin
                        w_next  = S_TRAP;
                        w_cause = 2'd1;
                    end else if (dec_branch) begin
                        pc_wr  = 1'b1;
                        pc_src = br_taken ? 2'd1 : 2'd0;
                        w_next = S_FETCH;
                    end else if (dec_jump || dec_jreg) begin
                        pc_wr  = 1'b1;
                        pc_src = dec_jump ? 2'd2 : 2'd3;
                        reg_wr = dec_regwr;
                        w_next = S_FETCH;
                    end else if (dec_load || dec_store) begin
                        w_next = S_MEM;
                    end else begin
                        w_next = S_WB;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_wr  = dec_store;
                    if (mem_ack) begin
                        if (dm_error) begin
                            w_next  = S_TRAP;
                            w_cause = 2'd2;
                        end else if (dec_store) begin
                            pc_wr  = 1'b1;
                            w_next = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end else if (w_tmo) begin
                        w_next  = S_TRAP;
                        w_cause = 2'd3;
                    end
                end
                S_WB: begin
                    reg_wr = dec_regwr;
                    wb_mem = dec_load;
                    pc_wr  = 1'b1;
                    w_next = S_FETCH;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = r_cause;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cause   <= 2'd0;
            r_wait    <= 8'd0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            r_wait  <= (mem_req && !mem_ack) ? r_wait + 8'd1 : 8'd0;
            if (pc_wr)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign state   = reset ? 3'd0 : r_state;
    assign instret = reset ? '0 : r_instret;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed and random instruction streams checked
// cycle by cycle against a per-instruction expansion model.
module tb_mips_mc_ctrl;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dec_load = 1'b0, dec_store = 1'b0, dec_branch = 1'b0;
    logic       dec_jump = 1'b0, dec_jreg = 1'b0, dec_regwr = 1'b0;
    logic       dec_ovfchk = 1'b0, br_taken = 1'b0, alu_of = 1'b0;
    logic       dm_error = 1'b0, mem_ack = 1'b0;
    logic       mem_req, mem_wr, mem_ifetch, ir_wr, pc_wr;
    logic [1:0] pc_src;
    logic       reg_wr, wb_mem, trap;
    logic [1:0] trap_cause;
    logic [2:0] state;
    logic [3:0] instret;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .dec_load(dec_load), .dec_store(dec_store),
        .dec_branch(dec_branch), .dec_jump(dec_jump),
        .dec_jreg(dec_jreg), .dec_regwr(dec_regwr),
        .dec_ovfchk(dec_ovfchk), .br_taken(br_taken),
        .alu_of(alu_of), .dm_error(dm_error), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_ifetch(mem_ifetch),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
        .reg_wr(reg_wr), .wb_mem(wb_mem), .trap(trap),
        .trap_cause(trap_cause), .state(state), .instret(instret)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       req, wr, ifc, irw, pcw;
        logic [1:0] src;
        logic       rw, wbm, trp;
        logic [1:0] cause;
        logic [3:0] ret;
    } out_t;

    typedef struct {
        out_t o;
        logic ack;
    } cyc_t;

    typedef struct {
        logic ld, st, br, j, jr, rw, ovc, of, bt, err;
        int   fw, mw, tl;
    } ins_t;

    cyc_t exp_q[$];
    int   m_ret;
    int   n_vec;
    int   n_bad;

    function automatic cyc_t blank(input logic [2:0] s);
        cyc_t c;
        c.o     = '0;
        c.o.st  = s;
        c.o.ret = 4'(m_ret);
        c.ack   = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic void push_wait(input logic [2:0] s,
                                      input logic wr);
        cyc_t c;
        c       = blank(s);
        c.o.req = 1'b1;
        c.o.ifc = (s == 3'd0);
        c.o.wr  = wr;
        c.ack   = 1'b0;
        exp_q.push_back(c);
    endfunction

    function automatic void push_trap(input logic [1:0] cause,
                                      input int n);
        cyc_t c;
        for (int k = 0; k < n; k++) begin
            c         = blank(3'd7);
            c.o.trp   = 1'b1;
            c.o.cause = cause;
            exp_q.push_back(c);
        end
    endfunction

    function automatic void retire(input cyc_t c);
        exp_q.push_back(c);
        m_ret = (m_ret + 1) % 16;
    endfunction

    // Expand one instruction into its expected cycle trace.
    function automatic void build(input ins_t in);
        cyc_t c;
        if (in.fw >= TMO) begin
            for (int k = 0; k < TMO; k++) push_wait(3'd0, 1'b0);
            push_trap(2'd3, in.tl);
            return;
        end
        for (int k = 0; k < in.fw; k++) push_wait(3'd0, 1'b0);
        c       = blank(3'd0);
        c.o.req = 1'b1;
        c.o.ifc = 1'b1;
        c.o.irw = 1'b1;
        c.ack   = 1'b1;
        exp_q.push_back(c);
        exp_q.push_back(blank(3'd1));
        c = blank(3'd2);
        if (in.ovc && in.of) begin
            exp_q.push_back(c);
            push_trap(2'd1, in.tl);
            return;
        end
        if (in.br) begin
            c.o.pcw = 1'b1;
            c.o.src = in.bt ? 2'd1 : 2'd0;
            retire(c);
            return;
        end
        if (in.j || in.jr) begin
            c.o.pcw = 1'b1;
            c.o.src = in.j ? 2'd2 : 2'd3;
            c.o.rw  = in.rw;
            retire(c);
            return;
        end
        exp_q.push_back(c);
        if (in.ld || in.st) begin
            if (in.mw >= TMO) begin
                for (int k = 0; k < TMO; k++) push_wait(3'd3, in.st);
                push_trap(2'd3, in.tl);
                return;
            end
            for (int k = 0; k < in.mw; k++) push_wait(3'd3, in.st);
            c       = blank(3'd3);
            c.o.req = 1'b1;
            c.o.wr  = in.st;
            c.ack   = 1'b1;
            if (in.err) begin
                exp_q.push_back(c);
                push_trap(2'd2, in.tl);
                return;
            end
            if (in.st) begin
                c.o.pcw = 1'b1;
                retire(c);
                return;
            end
            exp_q.push_back(c);
        end
        c       = blank(3'd4);
        c.o.rw  = in.rw;
        c.o.wbm = in.ld;
        c.o.pcw = 1'b1;
        retire(c);
    endfunction

    function automatic ins_t rand_ins();
        ins_t in;
        int   k;
        in    = '{default: 0};
        in.tl = 3;
        in.of = 1'($urandom_range(0, 1));
        in.bt = 1'($urandom_range(0, 1));
        in.rw = 1'($urandom_range(0, 1));
        in.fw = ($urandom_range(0, 39) == 0) ? int'($urandom_range(8, 10))
              : ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
        in.mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(8, 10))
              : int'($urandom_range(0, 3));
        k = int'($urandom_range(0, 9));
        case (k)
            4: begin in.br = 1'b1; in.rw = 1'b0; end
            5: in.j = 1'b1;
            6: in.jr = 1'b1;
            7: begin
                in.ld  = 1'b1;
                in.rw  = 1'b1;
                in.err = ($urandom_range(0, 15) == 0);
            end
            8: begin
                in.st  = 1'b1;
                in.rw  = 1'b0;
                in.err = ($urandom_range(0, 15) == 0);
            end
            default: begin
                in.ovc = 1'($urandom_range(0, 1));
                if (in.ovc)
                    in.of = ($urandom_range(0, 7) == 0);
            end
        endcase
        if (!in.ld && !in.st)
            in.err = 1'($urandom_range(0, 1));
        return in;
    endfunction

    task automatic step(input cyc_t c, input ins_t in,
                        input logic rst, output out_t o);
        @(negedge clk);
        reset      = rst;
        dec_load   = in.ld;
        dec_store  = in.st;
        dec_branch = in.br;
        dec_jump   = in.j;
        dec_jreg   = in.jr;
        dec_regwr  = in.rw;
        dec_ovfchk = in.ovc;
        alu_of     = in.of;
        br_taken   = in.bt;
        dm_error   = in.err;
        mem_ack    = c.ack;
        #1;
        o = out_t'({state, mem_req, mem_wr, mem_ifetch, ir_wr, pc_wr,
                    pc_src, reg_wr, wb_mem, trap, trap_cause, instret});
    endtask

    task automatic test_reset();
        ins_t in;
        cyc_t c;
        out_t o;
        in     = '{default: 1};
        c.o    = '0;
        c.ack  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(c, in, 1'b1, o);
            n_vec++;
            if (o !== c.o) begin
                n_bad++;
                $display("FAIL reset got %h exp %h", o, c.o);
            end
        end
        exp_q.delete();
        m_ret = 0;
    endtask

    task automatic test_alu();
        ins_t in;
        cyc_t c;
        out_t o;
        in    = '{default: 0};
        in.rw = 1'b1;
        in.ovc = 1'b1;
        in.tl = 3;
        build(in);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            c.ack = 1'b1;
            step(c, in, 1'b0, o);
            n_vec++;
            if (o !== c.o) begin
                n_bad++;
                $display("FAIL alu got %h exp %h", o, c.o);
            end
        end
    endtask

    task automatic test_load_wait();
        ins_t in;
        cyc_t c;
        out_t o;
        in    = '{default: 0};
        in.ld = 1'b1;
        in.rw = 1'b1;
        in.mw = 2;
        in.tl = 3;
        build(in);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            step(c, in, 1'b0, o);
            n_vec++;
            if (o !== c.o) begin
                n_bad++;
                $display("FAIL load_wait got %h exp %h", o, c.o);
            end
        end
    endtask

    task automatic test_branch_jal();
        ins_t in;
        cyc_t c;
        out_t o;
        for (int t = 0; t < 3; t++) begin
            in    = '{default: 0};
            in.tl = 3;
            if (t < 2) begin
                in.br = 1'b1;
                in.bt = (t == 0);
            end else begin
                in.j  = 1'b1;
                in.rw = 1'b1;
            end
            build(in);
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                step(c, in, 1'b0, o);
                n_vec++;
                if (o !== c.o) begin
                    n_bad++;
                    $display("FAIL branch_jal%0d got %h exp %h", t, o, c.o);
                end
            end
        end
    endtask

    task automatic test_overflow_trap();
        ins_t in;
        cyc_t c;
        out_t o;
        in     = '{default: 0};
        in.ovc = 1'b1;
        in.of  = 1'b1;
        in.rw  = 1'b1;
        in.tl  = 20;
        build(in);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            step(c, in, 1'b0, o);
            n_vec++;
            if (o !== c.o) begin
                n_bad++;
                $display("FAIL overflow got %h exp %h", o, c.o);
            end
        end
        test_reset();
    endtask

    task automatic test_timeout();
        ins_t in;
        cyc_t c;
        out_t o;
        in    = '{default: 0};
        in.fw = 20;
        in.tl = 4;
        build(in);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            step(c, in, 1'b0, o);
            n_vec++;
            if (o !== c.o) begin
                n_bad++;
                $display("FAIL timeout got %h exp %h", o, c.o);
            end
        end
        test_reset();
    endtask

    task automatic test_wrap();
        ins_t in;
        cyc_t c;
        out_t o;
        test_reset();
        for (int n = 0; n < 17; n++) begin
            in    = '{default: 0};
            in.rw = 1'b1;
            in.of = 1'($urandom_range(0, 1));
            in.tl = 3;
            build(in);
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                step(c, in, 1'b0, o);
                n_vec++;
                if (o !== c.o) begin
                    n_bad++;
                    $display("FAIL wrap%0d got %h exp %h", n, o, c.o);
                end
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_vec++;
        if (instret !== 4'd1) begin
            n_bad++;
            $display("FAIL wrap_count got %0d exp 1", instret);
        end
        test_reset();
    endtask

    task automatic test_reset_mid_mem();
        ins_t in;
        cyc_t c;
        out_t o;
        int   mcnt;
        in    = '{default: 0};
        in.ld = 1'b1;
        in.rw = 1'b1;
        in.mw = 6;
        in.tl = 3;
        mcnt  = 0;
        build(in);
        while (mcnt < 2 && exp_q.size() > 0) begin
            c = exp_q.pop_front();
            step(c, in, 1'b0, o);
            n_vec++;
            if (o !== c.o) begin
                n_bad++;
                $display("FAIL mid_mem got %h exp %h", o, c.o);
            end
            if (c.o.st == 3'd3) mcnt++;
        end
        test_reset();
        in    = '{default: 0};
        in.rw = 1'b1;
        in.tl = 3;
        build(in);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            step(c, in, 1'b0, o);
            n_vec++;
            if (o !== c.o) begin
                n_bad++;
                $display("FAIL after_reset got %h exp %h", o, c.o);
            end
        end
    endtask

    task automatic test_random();
        ins_t in;
        cyc_t c;
        out_t o;
        logic trapped;
        for (int n = 0; n < 300; n++) begin
            in = rand_ins();
            build(in);
            trapped = (exp_q[$].o.st == 3'd7);
            while (exp_q.size() > 0) begin
                c = exp_q.pop_front();
                step(c, in, 1'b0, o);
                n_vec++;
                if (o !== c.o) begin
                    n_bad++;
                    $display("FAIL random%0d got %h exp %h", n, o, c.o);
                end
            end
            if (trapped) test_reset();
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        m_ret = 0;
        test_reset();
        test_alu();
        test_load_wait();
        test_branch_jal();
        test_overflow_trap();
        test_timeout();
        test_wrap();
        test_reset_mid_mem();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Parametrised multi-cycle sequencer for the MIPS core. It replaces the single-cycle top's implicit one-instruction-per-clock control with an explicit FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memory share one variable-latency req/ack port. The block consumes instruction-class flags from the existing decoder plus ALU/data-memory status, drives PC, IR, register-file and memory enables, detects overflow, misalignment and bus-timeout traps, and counts retired instructions.

## Interface
- TIMEOUT, default 16: number of consecutive cycles `mem_req` may stay high without `mem_ack` before a bus-timeout trap. 0 disables the check. Legal range is 0..255.
- CNT_W, default 32: width of the retired-instruction counter.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- dec_load  in  1  current IR is a load.
- dec_store  in  1  current IR is a store.
- dec_branch  in  1  beq/bne/bgez/bgtz/blez/bltz.
- dec_jump  in  1  j/jal (imm26 target).
- dec_jreg  in  1  jr/jalr (register target).
- dec_regwr  in  1  instruction writes a register (includes link for jal/jalr).
- dec_ovfchk  in  1  add/sub/addi with overflow trap.
- br_taken  in  1  ALU branch-confirm.
- alu_of  in  1  ALU overflow flag.
- dm_error  in  1  data-memory misalignment, valid with `mem_ack` in MEM.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_wr  out  1  request is a write.
- mem_ifetch  out  1  address source: 1 selects PC, 0 selects ALUout.
- ir_wr  out  1  latch memory read data into IR.
- pc_wr  out  1  update PC.
- pc_src  out  2  next-PC source: 0 = PC+4, 1 = branch target, 2 = jump imm26, 3 = BusA.
- reg_wr  out  1  register-file write.
- wb_mem  out  1  BusW source: 1 selects memory data, 0 selects ALU or link.
- trap  out  1  sticky trap indication.
- trap_cause  out  2  0 = none, 1 = overflow, 2 = data misalignment, 3 = bus timeout.
- state  out  3  FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
- instret  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.

## Operation
- FETCH: assert `mem_req`=1, `mem_ifetch`=1, `mem_wr`=0.
  - On `mem_ack`: pulse `ir_wr` and go to DECODE.
  - `ack` in the same cycle `req` first rises is legal.
- DECODE: one cycle with no enables asserted. Go to EXEC.
- EXEC, evaluated in priority order:
  1. `dec_ovfchk & alu_of`: go to TRAP with cause 1. No `reg_wr`, no `pc_wr`.
  2. `dec_branch`: `pc_wr`=1; `pc_src`=1 if `br_taken`, else 0. Retire and go to FETCH.
  3. `dec_jump` or `dec_jreg`: `pc_wr`=1, `pc_src`=2 or 3 respectively, `reg_wr`=`dec_regwr` (link). Retire and go to FETCH.
  4. `dec_load` or `dec_store`: go to MEM.
  5. Otherwise: go to WB.
- MEM: `mem_req`=1, `mem_ifetch`=0, `mem_wr`=`dec_store`. On `mem_ack`:
  - `dm_error`: go to TRAP with cause 2. No write has been committed by this block; memory suppresses the write on error.
  - Store: `pc_wr`=1, `pc_src`=0. Retire and go to FETCH.
  - Load: go to WB.
- WB: `reg_wr`=`dec_regwr`, `wb_mem`=`dec_load`, `pc_wr`=1, `pc_src`=0. Retire and go to FETCH.
- Timeout: a wait counter clears whenever `mem_req` is low or `mem_ack` is high, and increments on each cycle with `req & !ack`.
  - When the counter reaches TIMEOUT with `ack` still low, go to TRAP with cause 3.
  - A TIMEOUT of 0 means the check never fires.
- TRAP: absorbing state. All enables are 0, `trap`=1, and `trap_cause` holds its value until reset.
- Retire: `instret` increments by 1 in each cycle that has `pc_wr`=1. This is exactly one per completed instruction.

## Timing
- Reset, while `reset` is high and on the following edge:
  - `state` = FETCH, `trap_cause` = 0, `instret` = 0, wait counter = 0.
  - All outputs read 0, including `mem_req`; outputs are gated by `reset`.
- `mem_req` first rises in the first cycle with `reset` low.
- Outputs are decoded from the registered state plus the current-cycle inputs (Mealy on `mem_ack`, `alu_of`, `br_taken`, `dm_error`).
- Minimum latency with zero-wait memory:
  - ALU op: 4 cycles (F, D, E, W).
  - Branch or jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1 cycle to the state it occurs in.
- Handshake: once `mem_req` is high it stays high with stable `mem_wr` and `mem_ifetch` until the `ack` cycle or a trap. `mem_ack` is ignored when `mem_req` is low.
- Reset mid-request: the request drops in the reset cycle. No `ir_wr`, `reg_wr` or `pc_wr` is issued for the aborted instruction.
- Overflow and bus-timeout traps never assert `reg_wr` or `pc_wr`. A misalignment trap never asserts `pc_wr`.
- `instret` wraps from 2^CNT_W−1 to 0 with no flag.

## Test plan
- ADD with no overflow, `mem_ack` tied high:
  - `state` sequence 0, 1, 2, 4, 0.
  - `reg_wr` and `pc_wr` high in cycle 4; `instret` 0→1.
- LW with `mem_ack` delayed 2 cycles in MEM:
  - MEM lasts 3 cycles with `mem_wr`=0 and `mem_ifetch`=0.
  - WB follows with `wb_mem`=1 and `reg_wr`=1; total 7 cycles.
- BEQ:
  - `br_taken`=1 gives `pc_src`=1; `br_taken`=0 gives `pc_src`=0.
  - Both take 3 cycles with `reg_wr`=0.
  - JAL gives `pc_src`=2 with `reg_wr`=1 in EXEC.
- ADD with `alu_of`=1 and `dec_ovfchk`=1:
  - `state`=7, `trap_cause`=1, no `reg_wr` or `pc_wr`.
  - Block stays in TRAP for 20 cycles; reset returns `state`=0 and `instret`=0.
- TIMEOUT=8 with `mem_ack` held low in FETCH: after 8 `req` cycles, `state`=7, `trap_cause`=3, `mem_req`=0.
- CNT_W=4: retire 17 ALU ops → `instret`=1. Reset asserted during a MEM wait → next cycle `mem_req`=0 and `state`=0.
